// File: rtl/chopper_sequencer.sv
// Fixed-off-time chopper for one coil phase: BLANK -> ON -> OFF cycling with
// a shared down-counter and a sticky fault after repeated short cycles.
module chopper_sequencer #(
  parameter int WIDTH       = 10,
  parameter int FAULT_LIMIT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [WIDTH-1:0] blank_time,
  input  logic [WIDTH-1:0] off_time,
  input  logic             overcurrent,
  input  logic             fault_clear,
  output logic             phase_on,
  output logic             blanking,
  output logic             off_start,
  output logic             fault,
  output logic [WIDTH-1:0] timer
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON, S_OFF} state_t;

  localparam logic [2:0] LIMIT = 3'(FAULT_LIMIT);

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [2:0]       short_reg;
  logic             first_on_reg;
  logic             off_start_reg;
  logic             fault_reg;

  logic [2:0] short_inc;
  logic       short_hit;

  assign short_inc = short_reg + 3'd1;
  // The short cycle that reaches the limit trips the fault instead of entering OFF.
  assign short_hit = enable && (state_reg == S_ON) && overcurrent &&
                     first_on_reg && (short_inc == LIMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      short_reg     <= '0;
      first_on_reg  <= 1'b0;
      off_start_reg <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      off_start_reg <= 1'b0;
      first_on_reg  <= 1'b0;
      if (!enable) begin
        state_reg <= S_IDLE;
        count_reg <= '0;
        short_reg <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (!fault_reg) begin
              state_reg <= S_BLANK;
              count_reg <= blank_time;
            end
          end
          S_BLANK: begin
            if (count_reg != '0) begin
              count_reg <= count_reg - 1'b1;
            end else begin
              state_reg    <= S_ON;
              first_on_reg <= 1'b1;
            end
          end
          S_ON: begin
            if (overcurrent) begin
              short_reg <= first_on_reg ? short_inc : 3'd0;
              if (short_hit) begin
                fault_reg <= 1'b1;
                state_reg <= S_IDLE;
              end else begin
                state_reg     <= S_OFF;
                count_reg     <= off_time;
                off_start_reg <= 1'b1;
              end
            end else begin
              first_on_reg <= 1'b0;
            end
          end
          S_OFF: begin
            if (count_reg != '0) begin
              count_reg <= count_reg - 1'b1;
            end else begin
              state_reg <= S_BLANK;
              count_reg <= blank_time;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            count_reg <= '0;
          end
        endcase
      end
      // A clear coinciding with a new fault loses, so the fault is never missed.
      if (fault_clear && !short_hit) begin
        fault_reg <= 1'b0;
        short_reg <= '0;
      end
    end
  end

  assign phase_on  = (state_reg == S_BLANK) || (state_reg == S_ON);
  assign blanking  = (state_reg == S_BLANK);
  assign off_start = off_start_reg;
  assign fault     = fault_reg;
  assign timer     = count_reg;

endmodule

// File: tb/tb_chopper_sequencer.sv
// Bench for chopper_sequencer: directed scenarios plus random traffic, all
// compared each cycle against a phase/elapsed-time model of the chopper.
module tb_chopper_sequencer;
  localparam int W   = 10;
  localparam int LIM = 4;
  localparam int P_IDLE = 0, P_BLANK = 1, P_ON = 2, P_OFF = 3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] blank_time = '0;
  logic [W-1:0] off_time = '0;
  logic         overcurrent = 1'b0;
  logic         fault_clear = 1'b0;
  logic         phase_on, blanking, off_start, fault;
  logic [W-1:0] timer;

  chopper_sequencer #(.WIDTH(W), .FAULT_LIMIT(LIM)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .blank_time(blank_time),
    .off_time(off_time), .overcurrent(overcurrent), .fault_clear(fault_clear),
    .phase_on(phase_on), .blanking(blanking), .off_start(off_start),
    .fault(fault), .timer(timer)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: current phase, its length in cycles, cycles already spent in it.
  int m_phase, m_len, m_elapsed, m_shorts, m_on_cycles;
  bit m_fault, m_pulse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_timer();
    return (m_phase == P_BLANK || m_phase == P_OFF) ? (m_len - 1 - m_elapsed) : 0;
  endfunction

  task automatic check_all();
    chk("phase_on",  32'(phase_on),  32'(m_phase == P_BLANK || m_phase == P_ON));
    chk("blanking",  32'(blanking),  32'(m_phase == P_BLANK));
    chk("off_start", 32'(off_start), 32'(m_pulse));
    chk("fault",     32'(fault),     32'(m_fault));
    chk("timer",     32'(timer),     32'(exp_timer()));
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_len = 0; m_elapsed = 0; m_shorts = 0;
    m_on_cycles = 0; m_fault = 0; m_pulse = 0;
  endtask

  task automatic model_edge();
    bit set_now;
    set_now = 0;
    m_pulse = 0;
    if (!enable) begin
      m_phase = P_IDLE; m_len = 0; m_elapsed = 0; m_shorts = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (!m_fault) begin
          m_phase = P_BLANK; m_len = int'(blank_time) + 1; m_elapsed = 0;
        end
        P_BLANK: if (m_elapsed + 1 < m_len) m_elapsed++;
                 else begin m_phase = P_ON; m_on_cycles = 0; m_len = 0; m_elapsed = 0; end
        P_ON: if (overcurrent) begin
          m_shorts = (m_on_cycles == 0) ? m_shorts + 1 : 0;
          if (m_shorts == LIM) begin
            set_now = 1; m_fault = 1; m_phase = P_IDLE;
          end else begin
            m_phase = P_OFF; m_len = int'(off_time) + 1; m_elapsed = 0; m_pulse = 1;
          end
        end else m_on_cycles++;
        default: if (m_elapsed + 1 < m_len) m_elapsed++;
                 else begin m_phase = P_BLANK; m_len = int'(blank_time) + 1; m_elapsed = 0; end
      endcase
    end
    if (fault_clear && !set_now) begin
      m_fault = 0; m_shorts = 0;
    end
  endtask

  // Drive inputs at the falling edge, model the rising edge, check at the next falling edge.
  task automatic step(input bit en, input bit oc, input bit fc);
    enable = en; overcurrent = oc; fault_clear = fc;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $display("FAIL %s observed=timeout expected=condition_reached", tag);
  endtask

  initial begin
    bit done;
    int blank_cnt;

    // Reset state
    model_reset();
    @(negedge clk);
    check_all();
    resetn = 1'b1;
    step(0, 0, 0);

    // Normal chop: comparator trips on the 10th ON cycle
    blank_time = 10'd3; off_time = 10'd5;
    blank_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      step(1, (m_phase == P_ON && m_on_cycles == 9), 0);
      if (i < 6 && blanking) blank_cnt++;
    end
    chk("normal_blank_len", 32'(blank_cnt), 32'd4);

    // Comparator held through BLANK must be ignored
    blank_time = 10'd4; off_time = 10'd2;
    for (int i = 0; i < 40; i++)
      step(1, (m_phase == P_BLANK) || (m_phase == P_ON && m_on_cycles == 2), 0);

    // Asynchronous reset while the OFF timer reads 3
    blank_time = 10'd2; off_time = 10'd6;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(1, (m_phase == P_ON), 0);
      done = (m_phase == P_OFF && exp_timer() == 3);
    end
    if (!done) timeout("reach_off_timer3");
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_phase_on", 32'(phase_on), 32'd0);
    chk("rst_blanking", 32'(blanking), 32'd0);
    chk("rst_off_start", 32'(off_start), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_timer", 32'(timer), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);

    // Short-cycle fault with comparator held high
    blank_time = 10'd2; off_time = 10'd1;
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      step(1, 1, 0);
      done = m_fault;
    end
    if (!done) timeout("reach_fault");
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    step(1, 1, 1);
    // Second run: clear asserted on the very edge the fault sets
    for (int i = 0; i < 50; i++)
      step(1, 1, (m_phase == P_ON && m_on_cycles == 0 && m_shorts == LIM - 1));
    step(0, 0, 1);

    // Disable mid-BLANK
    blank_time = 10'd5; off_time = 10'd5;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1, 0, 0);
      done = (m_phase == P_BLANK && m_elapsed == 2);
    end
    if (!done) timeout("reach_mid_blank");
    step(0, 0, 0);

    // Disable mid-OFF
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1, (m_phase == P_ON && m_on_cycles == 1), 0);
      done = (m_phase == P_OFF && m_elapsed == 2);
    end
    if (!done) timeout("reach_mid_off");
    step(0, 0, 0);

    // Zero blank and off times
    blank_time = 10'd0; off_time = 10'd0;
    for (int i = 0; i < 24; i++)
      step(1, (m_phase == P_ON && m_on_cycles == 1), 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        blank_time = W'($urandom_range(0, 6));
        off_time   = W'($urandom_range(0, 6));
      end
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
